// File: rtl/m_7segcon_gen.sv
// Multiplexed common-anode seven-segment scan controller with decimal points,
// frame-synchronous updates, leading-zero blanking, PWM brightness and anode guard time.
module m_7segcon_gen #(
    parameter int unsigned NDIGIT = 8,
    parameter int unsigned DELAY  = 100000,
    parameter int unsigned GUARD  = 16
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic [4*NDIGIT-1:0]   w_din,
    input  logic [NDIGIT-1:0]     w_dp,
    input  logic                  w_we,
    input  logic                  w_lzb,
    input  logic [3:0]            w_bright,
    output logic [6:0]            r_sg,
    output logic                  r_dp,
    output logic [NDIGIT-1:0]     r_an,
    output logic                  r_frame
);

    localparam int unsigned CW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int unsigned DW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
    localparam int unsigned VW = 4 * NDIGIT;

    logic [CW-1:0]     r_cnt;
    logic [DW-1:0]     r_digit;
    logic [3:0]        r_pwm;
    logic [VW-1:0]     r_val;
    logic [VW-1:0]     r_pval;
    logic [NDIGIT-1:0] r_dpv;
    logic [NDIGIT-1:0] r_pdp;
    logic              r_pend;

    logic              slot_end_c;
    logic              fb_c;
    logic              guard_ok_c;
    logic              lit_c;
    logic              blank_c;
    logic              dp_sel_c;
    logic [3:0]        nib_c;
    logic [6:0]        seg_c;
    logic [NDIGIT-1:0] blank_vec_c;

    assign slot_end_c = (r_cnt == CW'(DELAY - 1));
    assign fb_c       = slot_end_c && (r_digit == DW'(NDIGIT - 1));

    // Slot, digit and PWM counters
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt   <= '0;
            r_digit <= '0;
            r_pwm   <= '0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
            if (slot_end_c) begin
                r_cnt   <= '0;
                r_digit <= (r_digit == DW'(NDIGIT - 1)) ? '0 : r_digit + DW'(1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Writes are parked until the frame boundary so a frame is never torn
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_val  <= '0;
            r_dpv  <= '0;
            r_pval <= '0;
            r_pdp  <= '0;
            r_pend <= 1'b0;
        end else if (fb_c) begin
            if (w_we) begin
                r_val <= w_din;
                r_dpv <= w_dp;
            end else if (r_pend) begin
                r_val <= r_pval;
                r_dpv <= r_pdp;
            end
            r_pend <= 1'b0;
        end else if (w_we) begin
            r_pval <= w_din;
            r_pdp  <= w_dp;
            r_pend <= 1'b1;
        end
    end

    // A digit is blanked while it and every higher digit show a bare zero
    always_comb begin
        logic run;
        blank_vec_c = '0;
        run         = w_lzb;
        for (int k = int'(NDIGIT) - 1; k >= 0; k--) begin
            run            = run && (r_val[4*k +: 4] == 4'h0) && !r_dpv[k];
            blank_vec_c[k] = run;
        end
        blank_vec_c[0] = 1'b0;
    end

    always_comb begin
        nib_c    = 4'h0;
        dp_sel_c = 1'b0;
        blank_c  = 1'b0;
        for (int k = 0; k < int'(NDIGIT); k++) begin
            if (r_digit == DW'(k)) begin
                nib_c    = r_val[4*k +: 4];
                dp_sel_c = r_dpv[k];
                blank_c  = blank_vec_c[k];
            end
        end
    end

    // Hex font, active-high abcdefg
    always_comb begin
        seg_c = 7'h00;
        unique case (nib_c)
            4'h0: seg_c = 7'h7E;
            4'h1: seg_c = 7'h30;
            4'h2: seg_c = 7'h6D;
            4'h3: seg_c = 7'h79;
            4'h4: seg_c = 7'h33;
            4'h5: seg_c = 7'h5B;
            4'h6: seg_c = 7'h5F;
            4'h7: seg_c = 7'h70;
            4'h8: seg_c = 7'h7F;
            4'h9: seg_c = 7'h7B;
            4'hA: seg_c = 7'h77;
            4'hB: seg_c = 7'h1F;
            4'hC: seg_c = 7'h4E;
            4'hD: seg_c = 7'h3D;
            4'hE: seg_c = 7'h4F;
            4'hF: seg_c = 7'h47;
        endcase
    end

    generate
        if (GUARD == 0) begin : g_noguard
            assign guard_ok_c = 1'b1;
        end else begin : g_guard
            assign guard_ok_c = (r_cnt >= CW'(GUARD));
        end
    endgenerate

    assign lit_c = guard_ok_c && (r_pwm <= w_bright) && !blank_c;

    // Registered pin drivers; cathodes released whenever the anode is off
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_an    <= '1;
            r_sg    <= 7'h7F;
            r_dp    <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_an    <= lit_c ? ~(NDIGIT'(1) << r_digit) : '1;
            r_sg    <= lit_c ? ~seg_c : 7'h7F;
            r_dp    <= lit_c ? ~dp_sel_c : 1'b1;
            r_frame <= fb_c;
        end
    end

endmodule

// File: tb/tb_m_7segcon_gen.sv
// Bench for m_7segcon_gen: arithmetic reference model compared every cycle,
// plus directed scenarios with hand-computed pin values.
module tb_m_7segcon_gen;

    localparam int ND = 8;
    localparam int DL = 8;
    localparam int GD = 2;
    localparam int FR = ND * DL;

    logic        w_clk    = 1'b0;
    logic        w_rst_n  = 1'b0;
    logic [31:0] w_din    = '0;
    logic [7:0]  w_dp     = '0;
    logic        w_we     = 1'b0;
    logic        w_lzb    = 1'b0;
    logic [3:0]  w_bright = 4'hF;
    logic [6:0]  r_sg;
    logic        r_dp;
    logic [7:0]  r_an;
    logic        r_frame;

    int total = 0;
    int bad   = 0;

    logic [6:0] font [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Model: state index n counts clock edges since reset release
    int          mdl_n = 0;
    logic [31:0] mv = '0, pv = '0;
    logic [7:0]  mdp = '0, pdp = '0;
    logic        ppend = 1'b0;
    logic [7:0]  e_an = 8'hFF;
    logic [6:0]  e_sg = 7'h7F;
    logic        e_dp = 1'b1;
    logic        e_fr = 1'b0;

    m_7segcon_gen #(.NDIGIT(ND), .DELAY(DL), .GUARD(GD)) dut (
        .w_clk    (w_clk),
        .w_rst_n  (w_rst_n),
        .w_din    (w_din),
        .w_dp     (w_dp),
        .w_we     (w_we),
        .w_lzb    (w_lzb),
        .w_bright (w_bright),
        .r_sg     (r_sg),
        .r_dp     (r_dp),
        .r_an     (r_an),
        .r_frame  (r_frame)
    );

    always #5 w_clk = ~w_clk;

    function automatic int f_dig(input int n);
        return (n / DL) % ND;
    endfunction

    function automatic logic [3:0] f_nib(input int n, input logic [31:0] v);
        int d;
        d = f_dig(n);
        return v[4*d +: 4];
    endfunction

    function automatic logic f_blank(input int d, input logic [31:0] v, input logic [7:0] p,
                                     input logic lz);
        if (!lz || d == 0) return 1'b0;
        for (int k = d; k < ND; k++)
            if (v[4*k +: 4] != 4'h0 || p[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic f_lit(input int n, input logic [31:0] v, input logic [7:0] p,
                                   input logic lz, input logic [3:0] br);
        return ((n % DL) >= GD) && ((n % 16) <= int'(br)) && !f_blank(f_dig(n), v, p, lz);
    endfunction

    always @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            mdl_n <= 0;
            mv    <= '0;
            mdp   <= '0;
            pv    <= '0;
            pdp   <= '0;
            ppend <= 1'b0;
            e_an  <= 8'hFF;
            e_sg  <= 7'h7F;
            e_dp  <= 1'b1;
            e_fr  <= 1'b0;
        end else begin
            if (f_lit(mdl_n, mv, mdp, w_lzb, w_bright)) begin
                e_an <= ~(8'd1 << f_dig(mdl_n));
                e_sg <= ~font[f_nib(mdl_n, mv)];
                e_dp <= ~mdp[f_dig(mdl_n)];
            end else begin
                e_an <= 8'hFF;
                e_sg <= 7'h7F;
                e_dp <= 1'b1;
            end
            e_fr <= ((mdl_n % FR) == FR - 1);
            if ((mdl_n % FR) == FR - 1) begin
                if (w_we) begin
                    mv  <= w_din;
                    mdp <= w_dp;
                end else if (ppend) begin
                    mv  <= pv;
                    mdp <= pdp;
                end
                ppend <= 1'b0;
            end else if (w_we) begin
                pv    <= w_din;
                pdp   <= w_dp;
                ppend <= 1'b1;
            end
            mdl_n <= mdl_n + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge w_clk) begin
        chk("an", 32'(r_an), 32'(e_an));
        chk("sg", 32'(r_sg), 32'(e_sg));
        chk("dp", 32'(r_dp), 32'(e_dp));
        chk("frame", 32'(r_frame), 32'(e_fr));
        chk("an_onehot", 32'($countones(~r_an) <= 1), 32'd1);
    end

    // Returns 2 time units after the edge that leaves the model at state target
    task automatic wait_n(input int target);
        for (int i = 0; i < 2000 && mdl_n < target; i++) begin
            @(posedge w_clk);
            #2;
        end
        chk("reach_state", 32'(mdl_n), 32'(target));
    endtask

    initial begin
        repeat (3) @(posedge w_clk);
        #1;
        chk("rst_an", 32'(r_an), 32'hFF);
        chk("rst_sg", 32'(r_sg), 32'h7F);
        chk("rst_dp", 32'(r_dp), 32'h1);
        chk("rst_frame", 32'(r_frame), 32'h0);
        @(negedge w_clk);
        w_rst_n = 1'b1;

        wait_n(3);
        chk("first_an", 32'(r_an), 32'hFE);
        chk("first_sg", 32'(r_sg), 32'h01);

        // Write at the frame boundary itself
        wait_n(63);
        w_din = 32'h89ABCDEF;
        w_we  = 1'b1;
        wait_n(64);
        w_we = 1'b0;
        chk("frame_pulse", 32'(r_frame), 32'h1);
        wait_n(65);
        chk("frame_single", 32'(r_frame), 32'h0);
        wait_n(67);
        chk("hexF_an", 32'(r_an), 32'hFE);
        chk("hexF_sg", 32'(r_sg), 32'h38);

        // Mid-frame write must wait for the next frame
        wait_n(100);
        w_din = 32'h0;
        w_we  = 1'b1;
        wait_n(101);
        w_we = 1'b0;
        wait_n(123);
        chk("hex8_an", 32'(r_an), 32'h7F);
        chk("hex8_sg", 32'(r_sg), 32'h00);
        wait_n(131);
        chk("zero_an", 32'(r_an), 32'hFE);
        chk("zero_sg", 32'(r_sg), 32'h01);

        // Leading-zero blanking
        wait_n(135);
        w_din = 32'h00000120;
        w_lzb = 1'b1;
        w_we  = 1'b1;
        wait_n(136);
        w_we = 1'b0;
        wait_n(213);
        chk("lzb_d2_an", 32'(r_an), 32'hFB);
        chk("lzb_d2_sg", 32'(r_sg), 32'h4F);
        wait_n(221);
        chk("lzb_d3_an", 32'(r_an), 32'hFF);

        // A lit decimal point stops blanking below it
        wait_n(230);
        w_dp = 8'h20;
        w_we = 1'b1;
        wait_n(231);
        w_we = 1'b0;
        wait_n(301);
        chk("dp5_an", 32'(r_an), 32'hDF);
        chk("dp5_sg", 32'(r_sg), 32'h01);
        chk("dp5_dp", 32'(r_dp), 32'h0);
        wait_n(309);
        chk("dp6_an", 32'(r_an), 32'hFF);

        // Brightness 3: lit only while pwm is 0..3
        wait_n(320);
        w_bright = 4'd3;
        w_lzb    = 1'b0;
        wait_n(340);
        chk("pwm3_an", 32'(r_an), 32'hFB);
        wait_n(341);
        chk("pwm4_an", 32'(r_an), 32'hFF);

        // Reset mid-slot with a pending write
        wait_n(380);
        w_bright = 4'hF;
        wait_n(400);
        w_din = 32'h55555555;
        w_we  = 1'b1;
        wait_n(401);
        w_we = 1'b0;
        wait_n(413);
        #1;
        w_rst_n = 1'b0;
        #1;
        chk("arst_an", 32'(r_an), 32'hFF);
        chk("arst_sg", 32'(r_sg), 32'h7F);
        chk("arst_dp", 32'(r_dp), 32'h1);
        chk("arst_frame", 32'(r_frame), 32'h0);
        @(negedge w_clk);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        wait_n(3);
        chk("post_an", 32'(r_an), 32'hFE);
        chk("post_sg", 32'(r_sg), 32'h01);
        wait_n(67);
        chk("nopend_an", 32'(r_an), 32'hFE);
        chk("nopend_sg", 32'(r_sg), 32'h01);
        chk("nopend_dp", 32'(r_dp), 32'h1);

        @(negedge w_clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
